// File: rtl/btn_event_ctrl.sv
// Push-button front end: 2-flop synchroniser, per-channel debounce FSM, sticky
// write-one-to-clear press events and a wrapping total-press counter.
module btn_event_ctrl #(
    parameter int unsigned NBTN            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NBTN-1:0]  btn_raw_i,
    input  logic             clr_we_i,
    input  logic [NBTN-1:0]  clr_mask_i,
    output logic [NBTN-1:0]  btn_lvl_o,
    output logic [NBTN-1:0]  btn_evt_o,
    output logic             evt_any_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int unsigned DcW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DcW-1:0] DcMax = DcW'(DEBOUNCE_CYCLES);
    localparam logic [DcW-1:0] DcOne = DcW'(1);

    typedef enum logic [1:0] {
        StRel,
        StPwait,
        StPrs,
        StRwait
    } state_e;

    logic [NBTN-1:0]  sync1_q, sync2_q;
    state_e           state_q [NBTN];
    state_e           state_d [NBTN];
    logic [DcW-1:0]   dc_q [NBTN];
    logic [DcW-1:0]   dc_d [NBTN];
    logic [NBTN-1:0]  lvl_q, lvl_d;
    logic [NBTN-1:0]  evt_q, evt_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBTN-1:0]  set_evt;
    logic [CNT_W-1:0] n_press;

    always_comb begin
        lvl_d   = lvl_q;
        set_evt = '0;
        n_press = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            dc_d[i]    = dc_q[i];
            unique case (state_q[i])
                StRel: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StPwait;
                        dc_d[i]    = DcOne;
                    end
                end
                StPwait: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StRel;
                        dc_d[i]    = '0;
                    end else if (dc_q[i] == DcMax) begin
                        state_d[i] = StPrs;
                        dc_d[i]    = '0;
                        lvl_d[i]   = 1'b1;
                        set_evt[i] = 1'b1;
                    end else begin
                        dc_d[i] = dc_q[i] + DcOne;
                    end
                end
                StPrs: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StRwait;
                        dc_d[i]    = DcOne;
                    end
                end
                StRwait: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StPrs;
                        dc_d[i]    = '0;
                    end else if (dc_q[i] == DcMax) begin
                        state_d[i] = StRel;
                        dc_d[i]    = '0;
                        lvl_d[i]   = 1'b0;
                    end else begin
                        dc_d[i] = dc_q[i] + DcOne;
                    end
                end
                default: begin
                    state_d[i] = StRel;
                    dc_d[i]    = '0;
                end
            endcase
            n_press = n_press + CNT_W'(set_evt[i]);
        end
        // A new press on the same edge as its clear keeps the event set.
        evt_d = (evt_q & ~(clr_mask_i & {NBTN{clr_we_i}})) | set_evt;
        any_d = |evt_d;
        cnt_d = cnt_q + n_press;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            evt_q   <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= StRel;
                dc_q[i]    <= '0;
            end
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            evt_q   <= evt_d;
            any_q   <= any_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                dc_q[i]    <= dc_d[i];
            end
        end
    end

    assign btn_lvl_o   = lvl_q;
    assign btn_evt_o   = evt_q;
    assign evt_any_o   = any_q;
    assign press_cnt_o = cnt_q;

endmodule
